// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared encodings for the decode/control pipeline: instruction class
// (mode), arithmetic opcodes, condition codes, execute command codes, the
// per-stage control word and the condition-pass function.
// No ports (package).
package ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_ARITH = 2'b00,
    MODE_MEM   = 2'b01,
    MODE_BR    = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // Arithmetic opcodes (mode 00)
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Execute command codes
  localparam int         CMD_BITS = 4;
  localparam logic [3:0] CMD_MOV  = 4'b0001;
  localparam logic [3:0] CMD_ADD  = 4'b0010;
  localparam logic [3:0] CMD_ADC  = 4'b0011;
  localparam logic [3:0] CMD_SUB  = 4'b0100;
  localparam logic [3:0] CMD_SBC  = 4'b0101;
  localparam logic [3:0] CMD_AND  = 4'b0110;
  localparam logic [3:0] CMD_ORR  = 4'b0111;
  localparam logic [3:0] CMD_EOR  = 4'b1000;
  localparam logic [3:0] CMD_MVN  = 4'b1001;
  // Load/store uses the adder for address generation
  localparam logic [3:0] CMD_LDST = CMD_ADD;

  typedef struct packed {
    logic                valid;
    logic [CMD_BITS-1:0] cmd;
    logic                mem_r;
    logic                mem_w;
    logic                wb_en;
    logic                b;
    logic                set_flags;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

  // Condition evaluation against NZCV (n = bit 3 ... v = bit 0)
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] nzcv);
    logic n, z, cf, v, r;
    n  = nzcv[3];
    z  = nzcv[2];
    cf = nzcv[1];
    v  = nzcv[0];
    case (c)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = cf;
      COND_CC: r = ~cf;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = cf & ~z;
      COND_LS: r = ~cf | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Combinational instruction decode plus condition check. Produces the
// control word for stage 0 (a bubble when the opcode is illegal or the
// condition fails) and flags reserved mode / illegal opcode / cond 1111.
// Ports:
//   mode, op_code, s_in, cond : decoded instruction fields
//   sr                        : current NZCV used for the condition check
//   word                      : resulting control word
//   illegal                   : instruction is not executable as encoded
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] op_code,
  input  logic       s_in,
  input  logic [3:0] cond,
  input  logic [3:0] sr,
  output ctrl_word_t word,
  output logic       illegal
);

  ctrl_word_t raw;
  logic       legal;

  always_comb begin
    raw   = CTRL_BUBBLE;
    legal = 1'b1;
    case (mode_e'(mode))
      MODE_ARITH: begin
        raw.wb_en     = 1'b1;
        raw.set_flags = s_in;
        case (op_code)
          OP_MOV: raw.cmd = CMD_MOV;
          OP_MVN: raw.cmd = CMD_MVN;
          OP_ADD: raw.cmd = CMD_ADD;
          OP_ADC: raw.cmd = CMD_ADC;
          OP_SUB: raw.cmd = CMD_SUB;
          OP_SBC: raw.cmd = CMD_SBC;
          OP_AND: raw.cmd = CMD_AND;
          OP_ORR: raw.cmd = CMD_ORR;
          OP_EOR: raw.cmd = CMD_EOR;
          OP_CMP: begin
            raw.cmd   = CMD_SUB;
            raw.wb_en = 1'b0;
          end
          OP_TST: begin
            raw.cmd   = CMD_AND;
            raw.wb_en = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      MODE_MEM: begin
        raw.cmd   = CMD_LDST;
        raw.mem_r = s_in;
        raw.mem_w = ~s_in;
        raw.wb_en = s_in;
      end
      MODE_BR:  raw.b = 1'b1;
      default:  legal = 1'b0;
    endcase
    raw.valid = 1'b1;

    illegal = ~legal | (cond == COND_NV);
    word    = (legal && cond_pass(cond, sr)) ? raw : CTRL_BUBBLE;
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
// Control pipeline after decode: NUM_STAGES registered control words
// (index 0 = ID/EX), status register, branch flush and hazard stall.
// Optional feature: define CTRL_MEM_WAIT_EN to freeze the whole pipe while
// the memory stage (index 1) waits for mem_ready.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   in_valid, mode, op_code, s_in, cond: decoded instruction
//   hazard                            : stall request (stage 0 bubble)
//   alu_nzcv                          : flags of the stage-0 instruction
//   mem_ready                         : data memory access complete
//   in_ready                          : decode may advance
//   st_valid/st_cmd/st_mem_r/st_mem_w/st_wb_en/st_b : per-stage control
//   flush_out                         : taken branch in stage 0
//   sr                                : NZCV status register
//   illegal                           : one-cycle illegal-instruction pulse
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int CMD_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [1:0]                  mode,
  input  logic [3:0]                  op_code,
  input  logic                        s_in,
  input  logic [3:0]                  cond,
  input  logic                        hazard,
  input  logic [3:0]                  alu_nzcv,
  input  logic                        mem_ready,
  output logic                        in_ready,
  output logic [NUM_STAGES-1:0]       st_valid,
  output logic [NUM_STAGES*CMD_W-1:0] st_cmd,
  output logic [NUM_STAGES-1:0]       st_mem_r,
  output logic [NUM_STAGES-1:0]       st_mem_w,
  output logic [NUM_STAGES-1:0]       st_wb_en,
  output logic [NUM_STAGES-1:0]       st_b,
  output logic                        flush_out,
  output logic [3:0]                  sr,
  output logic                        illegal
);

  ctrl_word_t dec_word;
  logic       dec_illegal;
  logic       freeze;
  logic       take;
  ctrl_word_t next_p0;
  logic       set_flags_p0;

  ctrl_decode u_decode (
    .mode    (mode),
    .op_code (op_code),
    .s_in    (s_in),
    .cond    (cond),
    .sr      (sr),
    .word    (dec_word),
    .illegal (dec_illegal)
  );

`ifdef CTRL_MEM_WAIT_EN
  assign freeze = st_valid[1] & (st_mem_r[1] | st_mem_w[1]) & ~mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign freeze           = 1'b0;
`endif

  assign flush_out = st_valid[0] & st_b[0];
  assign in_ready  = ~hazard & ~freeze;
  // A flush discards the instruction in decode; hazard holds it back.
  assign take      = in_valid & ~hazard & ~flush_out;
  assign next_p0   = take ? dec_word : CTRL_BUBBLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid     <= '0;
      st_cmd       <= '0;
      st_mem_r     <= '0;
      st_mem_w     <= '0;
      st_wb_en     <= '0;
      st_b         <= '0;
      set_flags_p0 <= 1'b0;
      sr           <= 4'b0000;
      illegal      <= 1'b0;
    end else if (freeze) begin
      illegal <= 1'b0;
    end else begin
      // stage k-1 -> stage k; the last stage drops out
      for (int k = 1; k < NUM_STAGES; k++) begin
        st_valid[k]                <= st_valid[k-1];
        st_cmd[k*CMD_W +: CMD_W]   <= st_cmd[(k-1)*CMD_W +: CMD_W];
        st_mem_r[k]                <= st_mem_r[k-1];
        st_mem_w[k]                <= st_mem_w[k-1];
        st_wb_en[k]                <= st_wb_en[k-1];
        st_b[k]                    <= st_b[k-1];
      end
      // decode -> stage 0 (ID/EX)
      st_valid[0]      <= next_p0.valid;
      st_cmd[0 +: CMD_W] <= CMD_W'(next_p0.cmd);
      st_mem_r[0]      <= next_p0.mem_r;
      st_mem_w[0]      <= next_p0.mem_w;
      st_wb_en[0]      <= next_p0.wb_en;
      st_b[0]          <= next_p0.b;
      set_flags_p0     <= next_p0.set_flags;
      // flags are committed as the flag-setting word leaves stage 0
      if (st_valid[0] && set_flags_p0) sr <= alu_nzcv;
      illegal <= take & dec_illegal;
    end
  end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, s_in, hazard, mem_ready;
  logic [1:0]  mode;
  logic [3:0]  op_code, cond, alu_nzcv;
  logic        in_ready, flush_out, illegal;
  logic [2:0]  st_valid, st_mem_r, st_mem_w, st_wb_en, st_b;
  logic [11:0] st_cmd;
  logic [3:0]  sr;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.NUM_STAGES(3), .CMD_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .op_code(op_code),
    .s_in(s_in), .cond(cond), .hazard(hazard), .alu_nzcv(alu_nzcv),
    .mem_ready(mem_ready), .in_ready(in_ready), .st_valid(st_valid),
    .st_cmd(st_cmd), .st_mem_r(st_mem_r), .st_mem_w(st_mem_w),
    .st_wb_en(st_wb_en), .st_b(st_b), .flush_out(flush_out), .sr(sr),
    .illegal(illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] op,
                       input logic s, input logic [3:0] c);
    in_valid = v; mode = m; op_code = op; s_in = s; cond = c;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 4'b1110);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; hazard = 1'b0; mem_ready = 1'b1; alu_nzcv = 4'b0000;
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 4'b1110);
    step(); step();
    rst = 1'b0;
    #1;
    tests_run++; if (st_valid !== 3'b000) begin tests_failed++; $display("FAIL reset_valid: got %b want 000", st_valid); end
    tests_run++; if (st_cmd !== 12'h000) begin tests_failed++; $display("FAIL reset_cmd: got %h want 000", st_cmd); end
    tests_run++; if (sr !== 4'b0000) begin tests_failed++; $display("FAIL reset_sr: got %b want 0000", sr); end
    tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_latency();
    drive(1'b1, 2'b00, 4'b0100, 1'b0, 4'b1110);
    step();
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 4'b1110);
    tests_run++; if (st_valid !== 3'b001) begin tests_failed++; $display("FAIL add_v0: got %b want 001", st_valid); end
    tests_run++; if (st_cmd[3:0] !== 4'b0010) begin tests_failed++; $display("FAIL add_cmd0: got %b want 0010", st_cmd[3:0]); end
    tests_run++; if (st_wb_en[0] !== 1'b1) begin tests_failed++; $display("FAIL add_wb0: got %b want 1", st_wb_en[0]); end
    step();
    tests_run++; if (st_valid !== 3'b010) begin tests_failed++; $display("FAIL add_v1: got %b want 010", st_valid); end
    step();
    tests_run++; if (st_valid !== 3'b100) begin tests_failed++; $display("FAIL add_v2: got %b want 100", st_valid); end
    tests_run++; if (st_cmd[11:8] !== 4'b0010 || st_wb_en[2] !== 1'b1) begin tests_failed++; $display("FAIL add_s2: got cmd %b wb %b want 0010 1", st_cmd[11:8], st_wb_en[2]); end
    step();
    tests_run++; if (st_valid !== 3'b000) begin tests_failed++; $display("FAIL add_drain: got %b want 000", st_valid); end
  endtask

  // {opcode, expected cmd, expected wb_en}
  logic [8:0] arith_tbl [11] = '{
    9'b1101_0001_1, 9'b1111_1001_1, 9'b0100_0010_1, 9'b0101_0011_1,
    9'b0010_0100_1, 9'b0110_0101_1, 9'b0000_0110_1, 9'b1100_0111_1,
    9'b0001_1000_1, 9'b1010_0100_0, 9'b1000_0110_0};

  task automatic test_arith_decode();
    logic [8:0] e;
    for (int i = 0; i < 11; i++) begin
      e = arith_tbl[i];
      drive(1'b1, 2'b00, e[8:5], 1'b0, 4'b1110);
      step();
      tests_run++;
      if (st_valid[0] !== 1'b1 || st_cmd[3:0] !== e[4:1] || st_wb_en[0] !== e[0] || illegal !== 1'b0) begin
        tests_failed++;
        $display("FAIL arith_op_%b: got v%b cmd %b wb %b ill %b want v1 cmd %b wb %b ill 0",
                 e[8:5], st_valid[0], st_cmd[3:0], st_wb_en[0], illegal, e[4:1], e[0]);
      end
    end
    drive(1'b1, 2'b00, 4'b0011, 1'b0, 4'b1110);
    step();
    tests_run++; if (illegal !== 1'b1 || st_valid[0] !== 1'b0) begin tests_failed++; $display("FAIL bad_opcode: got ill %b v0 %b want 1 0", illegal, st_valid[0]); end
    idle(3);
  endtask

  task automatic test_mem_decode();
    drive(1'b1, 2'b01, 4'b0000, 1'b1, 4'b1110);
    step();
    tests_run++; if ({st_valid[0], st_cmd[3:0], st_mem_r[0], st_mem_w[0], st_wb_en[0]} !== 8'b1_0010_101) begin tests_failed++; $display("FAIL ldr_word: got %b want 10010101", {st_valid[0], st_cmd[3:0], st_mem_r[0], st_mem_w[0], st_wb_en[0]}); end
    drive(1'b1, 2'b01, 4'b0000, 1'b0, 4'b1110);
    step();
    tests_run++; if ({st_valid[0], st_cmd[3:0], st_mem_r[0], st_mem_w[0], st_wb_en[0]} !== 8'b1_0010_010) begin tests_failed++; $display("FAIL str_word: got %b want 10010010", {st_valid[0], st_cmd[3:0], st_mem_r[0], st_mem_w[0], st_wb_en[0]}); end
    idle(3);
  endtask

  task automatic test_branch_flush();
    drive(1'b1, 2'b10, 4'b0000, 1'b0, 4'b1110);
    step();
    drive(1'b1, 2'b00, 4'b0100, 1'b0, 4'b1110);
    hazard = 1'b1;
    #1;
    tests_run++; if (flush_out !== 1'b1 || st_b[0] !== 1'b1 || st_cmd[3:0] !== 4'b0000) begin tests_failed++; $display("FAIL br_flush: got flush %b b0 %b cmd %b want 1 1 0000", flush_out, st_b[0], st_cmd[3:0]); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL br_hazard_ready: got %b want 0", in_ready); end
    step();
    hazard = 1'b0;
    #1;
    tests_run++; if (st_valid !== 3'b010 || st_b[1] !== 1'b1 || flush_out !== 1'b0) begin tests_failed++; $display("FAIL br_bubble: got v %b b1 %b flush %b want 010 1 0", st_valid, st_b[1], flush_out); end
    step();
    tests_run++; if (st_valid !== 3'b101 || st_b[2] !== 1'b1) begin tests_failed++; $display("FAIL br_single_bubble: got v %b b2 %b want 101 1", st_valid, st_b[2]); end
    // flush alone discards the instruction in decode
    drive(1'b1, 2'b10, 4'b0000, 1'b0, 4'b1110);
    step();
    drive(1'b1, 2'b00, 4'b0100, 1'b0, 4'b1110);
    step();
    tests_run++; if (st_valid[0] !== 1'b0 || st_b[1] !== 1'b1) begin tests_failed++; $display("FAIL br_discard: got v0 %b b1 %b want 0 1", st_valid[0], st_b[1]); end
    idle(3);
  endtask

  task automatic test_flags_cond();
    drive(1'b1, 2'b00, 4'b0010, 1'b1, 4'b1110);
    step();
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 4'b1110);
    alu_nzcv = 4'b0100;
    step();
    tests_run++; if (sr !== 4'b0100) begin tests_failed++; $display("FAIL subs_sr: got %b want 0100", sr); end
    drive(1'b1, 2'b00, 4'b0000, 1'b0, 4'b0000);
    alu_nzcv = 4'b0000;
    step();
    tests_run++; if (st_valid[0] !== 1'b1 || st_cmd[3:0] !== 4'b0110) begin tests_failed++; $display("FAIL and_eq_pass: got v0 %b cmd %b want 1 0110", st_valid[0], st_cmd[3:0]); end
    drive(1'b1, 2'b00, 4'b0000, 1'b0, 4'b0001);
    alu_nzcv = 4'b1111;
    step();
    tests_run++; if (st_valid[0] !== 1'b0 || illegal !== 1'b0) begin tests_failed++; $display("FAIL and_ne_fail: got v0 %b ill %b want 0 0", st_valid[0], illegal); end
    tests_run++; if (sr !== 4'b0100) begin tests_failed++; $display("FAIL sr_no_s: got %b want 0100", sr); end
    drive(1'b1, 2'b00, 4'b0100, 1'b0, 4'b1100);
    step();
    tests_run++; if (st_valid[0] !== 1'b0) begin tests_failed++; $display("FAIL gt_fail: got %b want 0", st_valid[0]); end
    drive(1'b1, 2'b00, 4'b0100, 1'b0, 4'b1010);
    step();
    tests_run++; if (st_valid[0] !== 1'b1) begin tests_failed++; $display("FAIL ge_pass: got %b want 1", st_valid[0]); end
    alu_nzcv = 4'b0000;
    idle(3);
  endtask

  task automatic test_illegal();
    drive(1'b1, 2'b11, 4'b0100, 1'b0, 4'b1110);
    step();
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 4'b1110);
    tests_run++; if (illegal !== 1'b1 || st_valid[0] !== 1'b0) begin tests_failed++; $display("FAIL mode11: got ill %b v0 %b want 1 0", illegal, st_valid[0]); end
    step();
    tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("FAIL ill_pulse: got %b want 0", illegal); end
    drive(1'b1, 2'b00, 4'b0100, 1'b0, 4'b1111);
    step();
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 4'b1110);
    tests_run++; if (illegal !== 1'b1 || st_valid[0] !== 1'b0) begin tests_failed++; $display("FAIL cond_nv: got ill %b v0 %b want 1 0", illegal, st_valid[0]); end
    idle(2);
  endtask

  task automatic test_mem_wait();
    drive(1'b1, 2'b01, 4'b0000, 1'b1, 4'b1110);
    step();
    drive(1'b1, 2'b00, 4'b0100, 1'b0, 4'b1110);
    step();
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 4'b1110);
    mem_ready = 1'b0;
    #1;
`ifdef CTRL_MEM_WAIT_EN
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL wait_ready_%0d: got %b want 0", i, in_ready); end
      step();
      tests_run++; if (st_valid !== 3'b011 || st_mem_r[1] !== 1'b1) begin tests_failed++; $display("FAIL wait_frozen_%0d: got v %b mr1 %b want 011 1", i, st_valid, st_mem_r[1]); end
    end
    mem_ready = 1'b1;
    step();
    tests_run++; if (st_valid !== 3'b110 || st_mem_r[2] !== 1'b1) begin tests_failed++; $display("FAIL wait_release: got v %b mr2 %b want 110 1", st_valid, st_mem_r[2]); end
`else
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL nowait_ready: got %b want 1", in_ready); end
    step();
    tests_run++; if (st_valid !== 3'b110 || st_mem_r[2] !== 1'b1) begin tests_failed++; $display("FAIL nowait_advance: got v %b mr2 %b want 110 1", st_valid, st_mem_r[2]); end
    mem_ready = 1'b1;
`endif
    idle(3);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'b00, 4'b0100, 1'b0, 4'b1110);
    step();
    step();
    rst = 1'b1; hazard = 1'b1; mem_ready = 1'b0;
    step();
    rst = 1'b0; hazard = 1'b0; mem_ready = 1'b1;
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 4'b1110);
    #1;
    tests_run++; if (st_valid !== 3'b000 || sr !== 4'b0000 || illegal !== 1'b0) begin tests_failed++; $display("FAIL mid_reset: got v %b sr %b ill %b want 000 0000 0", st_valid, sr, illegal); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_arith_decode();
    test_mem_decode();
    test_branch_flush();
    test_flags_cond();
    test_illegal();
    test_mem_wait();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of registered control stages after decode (ID/EX, EX/MEM, MEM/WB); legal range 2..4.
REQ-002 Parameter CMD_W, default 4: width of the execute command field.
REQ-003 clk  in  1  rising-edge clock; the only clock.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  decoded fields carry a valid instruction this cycle.
REQ-006 mode  in  2  instruction class: 00 arithmetic, 01 load/store, 10 branch, 11 reserved.
REQ-007 op_code  in  4  arithmetic opcode.
REQ-008 s_in  in  1  S bit: set-flags for arithmetic, load(1)/store(0) for mode 01.
REQ-009 cond  in  4  condition field.
REQ-010 hazard  in  1  stall request from the hazard unit.
REQ-011 alu_nzcv  in  4  ALU flags belonging to the instruction in stage 0.
REQ-012 mem_ready  in  1  data memory access complete.
REQ-013 in_ready  out  1  decode may advance.
REQ-014 st_valid, st_cmd, st_mem_r, st_mem_w, st_wb_en, st_b  out  NUM_STAGES each (st_cmd NUM_STAGES*CMD_W)  per-stage control word; index 0 = ID/EX.
REQ-015 flush_out  out  1  branch taken in stage 0; fetch/decode discard.
REQ-016 sr  out  4  status register NZCV.
REQ-017 illegal  out  1  one-cycle pulse: reserved mode or cond 1111 accepted.

Function
REQ-018 Decode, mode 00: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, all with wb_en=1; CMP 1010->0100 and TST 1000->0110 with wb_en=0; any other opcode -> bubble with illegal pulse.
REQ-019 Decode, mode 01: cmd 0010; s_in=1 -> mem_r=1, wb_en=1; s_in=0 -> mem_w=1, wb_en=0.
REQ-020 Decode, mode 10: b=1, all other fields 0; mode 11: bubble with illegal pulse.
REQ-021 Condition pass against sr: EQ/NE Z; CS/CC C; MI/PL N; VS/VC V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1110 always; 1111 never, plus illegal pulse.
REQ-022 Failed condition loads stage 0 with a bubble (all fields 0).
REQ-023 Advance: when not stalled, stage k+1 <= stage k and stage 0 <= decoded word (bubble if in_valid=0); last stage drops out.
REQ-024 hazard=1: stage 0 loads a bubble, later stages advance, in_ready=0.
REQ-025 flush_out = st_valid[0] & st_b[0], combinational; on the next edge stage 0 loads a bubble regardless of in_valid.
REQ-026 Simultaneous hazard and flush: bubble, single cycle, no double-stall.
REQ-027 sr <= alu_nzcv on the edge leaving stage 0 iff st_valid[0], mode-00 word with s set, and pipe not frozen.
REQ-028 Latency: decode to st_*[k] is k+1 cycles.

Reset
REQ-029 On rst at an edge: all st_* = 0, sr = 0000, illegal = 0; in_ready = 1 the following cycle.
REQ-030 rst overrides stall, flush and mem wait in the same cycle; instructions in flight are discarded.

Configuration
REQ-031 Macro CTRL_MEM_WAIT_EN defined: while st_valid[1] & (st_mem_r[1] | st_mem_w[1]) & !mem_ready, every stage and sr freeze, in_ready=0, illegal suppressed.
REQ-032 Macro undefined: mem_ready ignored; the pipe never freezes.

Structure
REQ-033 Shared package ctrl_pkg holds mode, opcode, cond and CMD encodings plus the control-word struct.
REQ-034 Sub-module ctrl_decode: combinational decode plus condition check, instantiated once.

Verification
REQ-035 ADD, mode 00, op 0100, cond 1110, s 0 -> st_cmd[0]=0010, st_wb_en[0]=1 one cycle later, reaching st_*[2] after 3 cycles.
REQ-036 SUBS with alu_nzcv=0100, then cond 0000 AND -> sr=0100, AND passes with cmd 0110.
REQ-037 LDR (mode 01, s 1) with mem_ready low for 3 cycles (CTRL_MEM_WAIT_EN) -> stages frozen 3 cycles, in_ready=0; without the macro there is no freeze.
REQ-038 Branch with cond 1110 -> flush_out=1 for one cycle and the next stage 0 is a bubble; hazard in the same cycle adds no extra bubble.
REQ-039 Mode 11 or cond 1111 -> illegal pulses 1 cycle, bubble inserted; rst mid-stream -> all st_valid=0 and sr=0 next cycle.
